// File: rtl/mips_pkg.sv
// mips_pkg: op_e mnemonics, OPCODE_*/FUNCT_* encodings and loader state type shared by encoder and loader
package mips_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
    OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_J
  } op_e;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} load_state_e;
  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] OPCODE_J     = 6'h02;
  localparam logic [5:0] OPCODE_BEQ   = 6'h04;
  localparam logic [5:0] OPCODE_BNE   = 6'h05;
  localparam logic [5:0] OPCODE_ADDI  = 6'h08;
  localparam logic [5:0] OPCODE_SLTI  = 6'h0A;
  localparam logic [5:0] OPCODE_ANDI  = 6'h0C;
  localparam logic [5:0] OPCODE_ORI   = 6'h0D;
  localparam logic [5:0] OPCODE_LW    = 6'h23;
  localparam logic [5:0] OPCODE_SW    = 6'h2B;
  localparam logic [5:0] FUNCT_ADD    = 6'h20;
  localparam logic [5:0] FUNCT_SUB    = 6'h22;
  localparam logic [5:0] FUNCT_AND    = 6'h24;
  localparam logic [5:0] FUNCT_OR     = 6'h25;
  localparam logic [5:0] FUNCT_SLT    = 6'h2A;
endpackage

// File: rtl/instr_encode.sv
// instr_encode: combinational op_i + register/imm/target fields -> 32-bit MIPS word_o and legal_o flag
module instr_encode
  import mips_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        legal_o
);
  always_comb begin
    word_o  = '0;
    legal_o = 1'b1;
    case (op_i)
      OP_ADD:  word_o = {OPCODE_RTYPE, rs_i, rt_i, rd_i, 5'd0, FUNCT_ADD};
      OP_SUB:  word_o = {OPCODE_RTYPE, rs_i, rt_i, rd_i, 5'd0, FUNCT_SUB};
      OP_AND:  word_o = {OPCODE_RTYPE, rs_i, rt_i, rd_i, 5'd0, FUNCT_AND};
      OP_OR:   word_o = {OPCODE_RTYPE, rs_i, rt_i, rd_i, 5'd0, FUNCT_OR};
      OP_SLT:  word_o = {OPCODE_RTYPE, rs_i, rt_i, rd_i, 5'd0, FUNCT_SLT};
      OP_LW:   word_o = {OPCODE_LW, rs_i, rt_i, imm_i};
      OP_SW:   word_o = {OPCODE_SW, rs_i, rt_i, imm_i};
      OP_BEQ:  word_o = {OPCODE_BEQ, rs_i, rt_i, imm_i};
      OP_BNE:  word_o = {OPCODE_BNE, rs_i, rt_i, imm_i};
      OP_ADDI: word_o = {OPCODE_ADDI, rs_i, rt_i, imm_i};
      OP_SLTI: word_o = {OPCODE_SLTI, rs_i, rt_i, imm_i};
      OP_ANDI: word_o = {OPCODE_ANDI, rs_i, rt_i, imm_i};
      OP_ORI:  word_o = {OPCODE_ORI, rs_i, rt_i, imm_i};
      OP_J:    word_o = {OPCODE_J, target_i};
      default: legal_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/instr_loader_encoder.sv
// instr_loader_encoder: encodes req_* mnemonics into imem_* writes from address 0, holds core until cpu_run; err flags illegal ops
module instr_loader_encoder
  import mips_pkg::*;
#(
  parameter  int DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              cpu_run,
  output logic              err
);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  load_state_e       state_q, state_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d, err_q, err_d;
  logic [31:0]       word;
  logic              legal, xfer;
  instr_encode u_enc (
    .op_i(req_op), .rs_i(req_rs), .rt_i(req_rt), .rd_i(req_rd),
    .imm_i(req_imm), .target_i(req_target), .word_o(word), .legal_o(legal)
  );
  assign req_ready  = (state_q == LOAD) && (wcnt_q < FULL);
  assign xfer       = req_valid & req_ready;
  // reset gates the pulse so a write registered just before reset never reaches memory
  assign imem_we    = we_q & reset;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_count = wcnt_q;
  // hold the core off while the final word is still being written
  assign cpu_run    = (state_q == DONE) & ~we_q;
  assign err        = err_q;
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    err_d   = err_q;
    if (xfer) begin
      we_d  = legal;
      err_d = err_q | ~legal;
      if (legal) begin
        addr_d  = wcnt_q[ADDR_W-1:0];
        wdata_d = word;
        wcnt_d  = wcnt_q + 1'b1;
      end
    end
    case (state_q)
      LOAD: state_d = (finish || (xfer && legal && wcnt_q == LAST)) ? DONE : LOAD;
      IDLE, DONE: if (start) begin
        state_d = LOAD;
        wcnt_d  = '0;
        addr_d  = '0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_instr_loader_encoder.sv
// tb_instr_loader_encoder: directed self-checking bench for instr_loader_encoder
module tb_instr_loader_encoder;
  import mips_pkg::*;
  localparam int DEPTH = 64;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, finish = 1'b0, req_valid = 1'b0;
  logic [3:0]  req_op = '0;
  logic [4:0]  req_rs = '0, req_rt = '0, req_rd = '0;
  logic [15:0] req_imm = '0;
  logic [25:0] req_target = '0;
  logic        req_ready, imem_we, cpu_run, err;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [6:0]  word_count;
  int n_cmp = 0, n_bad = 0;
  instr_loader_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
    .req_target(req_target), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .word_count(word_count), .cpu_run(cpu_run), .err(err)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    req_valid = 1'b1; req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_imm = imm; req_target = tgt;
  endtask
  task automatic do_start;
    start = 1'b1; step; start = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b0;
    repeat (2) step;
    n_cmp++; if (imem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", imem_we); end
    n_cmp++; if (word_count !== 7'd0 || imem_addr !== 6'd0 || imem_wdata !== 32'd0) begin n_bad++; $display("FAIL reset_regs: cnt %0d addr %0d data %h want 0", word_count, imem_addr, imem_wdata); end
    n_cmp++; if (cpu_run !== 1'b0 || err !== 1'b0 || req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_flags: run %b err %b rdy %b want 000", cpu_run, err, req_ready); end
    reset = 1'b1; finish = 1'b1; step; finish = 1'b0; step;
    n_cmp++; if (cpu_run !== 1'b0 || req_ready !== 1'b0) begin n_bad++; $display("FAIL idle_finish: run %b rdy %b want 00", cpu_run, req_ready); end
  endtask
  task automatic test_single;
    do_start;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL load_ready: got %b want 1", req_ready); end
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    step;
    req_valid = 1'b0; finish = 1'b1;
    n_cmp++; if (imem_we !== 1'b1 || imem_addr !== 6'd0 || imem_wdata !== 32'h00221820) begin n_bad++; $display("FAIL single_write: we %b addr %0d data %h want 1 0 00221820", imem_we, imem_addr, imem_wdata); end
    n_cmp++; if (word_count !== 7'd1 || cpu_run !== 1'b0) begin n_bad++; $display("FAIL single_cnt: cnt %0d run %b want 1 0", word_count, cpu_run); end
    step; finish = 1'b0;
    n_cmp++; if (cpu_run !== 1'b1 || imem_we !== 1'b0 || req_ready !== 1'b0) begin n_bad++; $display("FAIL single_done: run %b we %b rdy %b want 1 0 0", cpu_run, imem_we, req_ready); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] exp_w [4] = '{32'h8C020004, 32'h1022FFFF, 32'h08000010, 32'h20050007};
    do_start;
    n_cmp++; if (cpu_run !== 1'b0 || word_count !== 7'd0) begin n_bad++; $display("FAIL b2b_restart: run %b cnt %0d want 0 0", cpu_run, word_count); end
    for (int i = 0; i < 4; i++) begin
      if (i == 0) send(OP_LW, 5'd0, 5'd2, 5'd0, 16'h0004, 26'h0);
      else if (i == 1) send(OP_BEQ, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
      else if (i == 2) send(OP_J, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
      else send(OP_ADDI, 5'd0, 5'd5, 5'd0, 16'h0007, 26'h0);
      step;
      n_cmp++; if (imem_we !== 1'b1 || imem_addr !== 6'(i) || imem_wdata !== exp_w[i]) begin n_bad++; $display("FAIL b2b_word%0d: we %b addr %0d data %h want 1 %0d %h", i, imem_we, imem_addr, imem_wdata, i, exp_w[i]); end
    end
    req_valid = 1'b0; finish = 1'b1; step; finish = 1'b0; step;
    n_cmp++; if (cpu_run !== 1'b1 || word_count !== 7'd4) begin n_bad++; $display("FAIL b2b_done: run %b cnt %0d want 1 4", cpu_run, word_count); end
  endtask
  task automatic test_illegal;
    do_start;
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    step;
    n_cmp++; if (imem_we !== 1'b1 || imem_addr !== 6'd0 || err !== 1'b0) begin n_bad++; $display("FAIL ill_first: we %b addr %0d err %b want 1 0 0", imem_we, imem_addr, err); end
    req_op = 4'hF;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL ill_ready: got %b want 1", req_ready); end
    step;
    n_cmp++; if (imem_we !== 1'b0 || err !== 1'b1 || word_count !== 7'd1) begin n_bad++; $display("FAIL ill_op: we %b err %b cnt %0d want 0 1 1", imem_we, err, word_count); end
    send(OP_SUB, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0);
    step;
    n_cmp++; if (imem_we !== 1'b1 || imem_addr !== 6'd1 || imem_wdata !== 32'h00222022) begin n_bad++; $display("FAIL ill_second: we %b addr %0d data %h want 1 1 00222022", imem_we, imem_addr, imem_wdata); end
    req_valid = 1'b0; step;
    n_cmp++; if (imem_we !== 1'b0 || word_count !== 7'd2 || err !== 1'b1) begin n_bad++; $display("FAIL ill_end: we %b cnt %0d err %b want 0 2 1", imem_we, word_count, err); end
  endtask
  task automatic test_finish_coincident;
    send(OP_ORI, 5'd3, 5'd4, 5'd0, 16'h00FF, 26'h0);
    finish = 1'b1; step; finish = 1'b0; req_valid = 1'b0;
    n_cmp++; if (imem_we !== 1'b1 || imem_addr !== 6'd2 || imem_wdata !== 32'h346400FF) begin n_bad++; $display("FAIL coin_write: we %b addr %0d data %h want 1 2 346400ff", imem_we, imem_addr, imem_wdata); end
    n_cmp++; if (cpu_run !== 1'b0 || word_count !== 7'd3) begin n_bad++; $display("FAIL coin_run_early: run %b cnt %0d want 0 3", cpu_run, word_count); end
    step;
    n_cmp++; if (cpu_run !== 1'b1 || req_ready !== 1'b0) begin n_bad++; $display("FAIL coin_done: run %b rdy %b want 1 0", cpu_run, req_ready); end
    do_start;
    n_cmp++; if (cpu_run !== 1'b0 || word_count !== 7'd0 || err !== 1'b0) begin n_bad++; $display("FAIL coin_restart: run %b cnt %0d err %b want 0 0 0", cpu_run, word_count, err); end
    send(OP_AND, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    step; req_valid = 1'b0;
    n_cmp++; if (imem_we !== 1'b1 || imem_addr !== 6'd0 || imem_wdata !== 32'h00221824) begin n_bad++; $display("FAIL coin_next: we %b addr %0d data %h want 1 0 00221824", imem_we, imem_addr, imem_wdata); end
    finish = 1'b1; step; finish = 1'b0; step;
  endtask
  task automatic test_fill;
    int nacc = 0, nwr = 0;
    logic [5:0] last_addr = '0;
    do_start;
    send(OP_ADDI, 5'd0, 5'd1, 5'd0, 16'h0001, 26'h0);
    for (int i = 0; i < DEPTH + 3; i++) begin
      if (req_ready) nacc++;
      step;
      if (imem_we) begin nwr++; last_addr = imem_addr; end
      if (i == DEPTH - 1) begin
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready_drop: got %b want 0", req_ready); end
      end
    end
    req_valid = 1'b0; step;
    n_cmp++; if (nacc != DEPTH || nwr != DEPTH) begin n_bad++; $display("FAIL fill_count: acc %0d wr %0d want %0d", nacc, nwr, DEPTH); end
    n_cmp++; if (last_addr !== 6'd63 || word_count !== 7'd64) begin n_bad++; $display("FAIL fill_last: addr %0d cnt %0d want 63 64", last_addr, word_count); end
    n_cmp++; if (cpu_run !== 1'b1 || req_ready !== 1'b0) begin n_bad++; $display("FAIL fill_done: run %b rdy %b want 1 0", cpu_run, req_ready); end
  endtask
  task automatic test_reset_mid_load;
    do_start;
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    step; req_valid = 1'b0; reset = 1'b0; #1;
    n_cmp++; if (imem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mid_we: got %b want 0", imem_we); end
    step;
    n_cmp++; if (imem_we !== 1'b0 || word_count !== 7'd0 || imem_addr !== 6'd0 || imem_wdata !== 32'd0) begin n_bad++; $display("FAIL rst_mid_regs: we %b cnt %0d addr %0d data %h want 0", imem_we, word_count, imem_addr, imem_wdata); end
    reset = 1'b1; step;
    n_cmp++; if (req_ready !== 1'b0 || cpu_run !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL rst_mid_idle: rdy %b run %b err %b want 000", req_ready, cpu_run, err); end
    do_start;
    n_cmp++; if (req_ready !== 1'b1 || word_count !== 7'd0) begin n_bad++; $display("FAIL rst_mid_restart: rdy %b cnt %0d want 1 0", req_ready, word_count); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_illegal;
    test_finish_coincident;
    test_fill;
    test_reset_mid_load;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_loader_encoder.md
Name: instr_loader_encoder

Overview:
Produces the instruction stream that the single-cycle core's control unit consumes. It accepts mnemonic-level instruction requests over a valid/ready handshake and encodes each into a 32-bit MIPS word (R/I/J format). Each word is written sequentially into instruction memory from word address 0. It holds the core stopped while loading and releases it with `cpu_run` once the program is complete.

Parameters:
- DEPTH, 64: instruction memory depth in words; maximum program length.
- ADDR_W, $clog2(DEPTH): word-address width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  pulse; begin a new load at address 0.
- finish  in  1  pulse; end of program.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts request this cycle.
- req_op  in  4  op_e mnemonic code.
- req_rs  in  5  source register rs.
- req_rt  in  5  register rt (I-type destination or data).
- req_rd  in  5  R-type destination.
- req_imm  in  16  immediate or branch offset (raw, no sign handling).
- req_target  in  26  J-type word target.
- imem_we  out  1  instruction memory write enable.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- word_count  out  ADDR_W+1  words written this load.
- cpu_run  out  1  core may execute.
- err  out  1  sticky illegal-op flag.

Behaviour:
- States: IDLE, LOAD, DONE. Reset puts the block in IDLE with every output 0 and the write address at 0.
- IDLE: `start` moves to LOAD. `req_ready` is 0.
- LOAD: `req_ready` = 1 while `word_count` < DEPTH.
  - A transfer is `req_valid` & `req_ready`.
  - A legal transfer in cycle N gives `imem_we` = 1, `imem_addr` = current address and `imem_wdata` = encoded word in cycle N+1 (one registered stage). The address and `word_count` increment, visible in N+1.
  - `imem_we` is a single-cycle pulse per accepted word. Back-to-back transfers write every cycle.
- Encoding:
  - R-type (add/sub/and/or/slt): {6'h00, rs, rt, rd, 5'd0, funct}, with funct = 20/22/24/25/2A hex.
  - I-type: {opcode, rs, rt, imm}, with lw 23, sw 2B, beq 04, bne 05, addi 08, slti 0A, andi 0C, ori 0D.
  - J: {6'h02, target}.
  - Fields not used by a format are ignored.
- Illegal op (code outside op_e): the request is still accepted (`req_ready` = 1), sets `err`, performs no write and does not advance the address.
- LOAD → DONE when `finish` = 1, or when `word_count` reaches DEPTH (auto-finish; `req_ready` drops in the same cycle the count reaches DEPTH).
  - If `finish` and a transfer occur in the same cycle, the word is still written in the following cycle, and `cpu_run` rises one cycle after that write.
- DONE: `cpu_run` = 1, `req_ready` = 0.
  - `start` returns to LOAD. `cpu_run` drops in the next cycle; the address, `word_count` and `err` clear.
- `start` during LOAD is ignored. `finish` in IDLE or DONE is ignored.
- Reset mid-load: immediate return to IDLE. A pending write is discarded and `imem_we` = 0 in the cycle after reset is sampled.
- `word_count` saturates at DEPTH and never wraps.

Decomposition:
- Package `mips_pkg`: `op_e` enum (ADD, SUB, AND, OR, SLT, LW, SW, BEQ, BNE, ADDI, SLTI, ANDI, ORI, J), OPCODE_* and FUNCT_* constants shared with the control unit's decoders, and `load_state_e`.
- Sub-module `instr_encode`: purely combinational, op/fields → {word, legal}. It is reusable by the bench as a golden model.

Test Plan:
- start, then add rs=1 rt=2 rd=3, then finish → `imem_we` at addr 0, data 0x00221820; `word_count` = 1; `cpu_run` = 1 two cycles after the transfer.
- Back-to-back lw rt=2 rs=0 imm=4, beq rs=1 rt=2 imm=FFFF, j target=0x10, addi rt=5 imm=7 → addrs 0..3, data 8C020004, 1022FFFF, 08000010, 20050007 on consecutive cycles.
- Illegal op 4'hF between two legal requests → `err` = 1, only 2 writes, at addrs 0 and 1.
- DEPTH+3 requests held valid → exactly DEPTH writes, `req_ready` low from the DEPTH-th acceptance, auto DONE, `word_count` = DEPTH.
- `finish` coincident with a transfer → that word is written, then DONE. Then `start` → `cpu_run` 0, `word_count` 0, `err` cleared, next write at addr 0.
- Reset asserted the cycle after a transfer → no `imem_we` is seen, state IDLE, all outputs 0.
